issue_queue_model: RTL
======================

Name: issue_queue_model

Overview:
- Parametrised stand-in for the backend issue queue, used by frontend testbenches in place of the always-ready sink.
- Buffers issued instructions in a FIFO of configurable depth. Drains them at a programmable rate, so the frontend sees realistic backpressure (ready low when full).
- Supports flush, and exposes dequeued entries and occupancy for scoreboarding.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- DATA_W, 64, width of the issued payload ({pc, instruction}).
- DRAIN_PERIOD, 1, cycles between drain ticks; >= 1, where 1 means one pop per cycle.
- CNT_W, $clog2(DEPTH+1), derived; width of count_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous flush, discards all entries.
- issue_valid_i  in  1  frontend has a valid instruction.
- issue_ready_o  out  1  queue can accept an instruction this cycle.
- issue_data_i  in  DATA_W  issued payload.
- drain_en_i  in  1  enables the drain tick counter.
- deq_valid_o  out  1  one-cycle pulse: an entry was popped last cycle.
- deq_data_o  out  DATA_W  payload of the popped entry.
- count_o  out  CNT_W  current occupancy, range 0..DEPTH.

Behaviour:
- Reset (rst_i=1 at an edge):
  - head pointer, tail pointer, count and drain counter go to 0.
  - deq_valid_o=0, deq_data_o='0.
  - Storage contents are don't-care.
- issue_ready_o is combinational: !full && !flush_i && !rst_i. It never depends on issue_valid_i.
- Push: happens when issue_valid_i && issue_ready_o. issue_data_i is written at the tail and the tail increments modulo DEPTH.
- Drain tick:
  - The drain counter increments each cycle drain_en_i=1.
  - When the counter equals DRAIN_PERIOD-1, tick=1 and the counter returns to 0.
  - When drain_en_i=0 the counter holds and there is no tick.
- Pop: happens on tick && !empty. The head entry is registered into deq_data_o, deq_valid_o=1 on the next cycle, and the head increments modulo DEPTH.
  - A tick while empty is lost; the counter still wraps.
- Without a pop, deq_valid_o=0 and deq_data_o holds its last value.
- Latency: minimum push-to-deq_valid_o latency is 2 cycles (push edge N, pop edge N+1, pulse visible after N+1).
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - When full, ready=0 even if a pop occurs in the same cycle (no bypass). Accepted push rate at full is therefore at most one per drain tick, with ready rising the cycle after the pop.
- Empty + push + tick in the same cycle: the pop does not occur (no fall-through). The entry pops at the next tick.
- count_o = registered occupancy; +1 on push only, -1 on pop only.
- Flush (flush_i=1, rst_i=0):
  - Pointers, count and drain counter go to 0.
  - Any push or pop that cycle is suppressed; deq_valid_o=0 next cycle.
  - Flush during a pending deq_valid_o pulse does not cancel the pulse already on the outputs.
- rst_i has priority over flush_i; flush_i has priority over push and pop.
- Pointer wrap: pointers are log2(DEPTH) bits; full/empty are derived from count, not pointer compare.

Decomposition:
- Package issue_queue_model_pkg holds:
  - typedef issue_entry_t (packed struct {pc[31:0], instr[31:0]}), matching the DATA_W default;
  - constant ISSUE_QUEUE_DEPTH_DEFAULT = 8.
- Sub-module sync_fifo_mem (DEPTH x DATA_W register array, one write port, one combinational read port at head). Pointer, count and drain logic stay in the top.

Test Plan:
- Reset then idle, DEPTH=8, drain_en_i=0 -> issue_ready_o=1, count_o=0, deq_valid_o=0.
- Fill with drain off: 8 back-to-back pushes (data 0x1..0x8) -> count_o=8, ready=0 on cycle 9; a 9th valid is held and not accepted.
- Drain order, DRAIN_PERIOD=1: enable drain after the fill -> deq_data_o = 0x1..0x8 on 8 consecutive pulses, count_o reaches 0, no further deq_valid_o.
- Rate, DRAIN_PERIOD=3, continuous valid -> steady state has exactly one push per 3 cycles once full; each pop is followed by ready=1 for one cycle.
- Simultaneous ops, DRAIN_PERIOD=1, count=4, valid every cycle -> count_o stays 4 and FIFO order is preserved through pointer wrap (>=16 pushes).
- Flush with count=5 and a tick due -> next cycle count_o=0, no deq_valid_o. A push in the flush cycle is dropped. A push the next cycle pops with the correct data.

Source files
------------

// File: rtl/issue_queue_model_pkg.sv
// Shared types and defaults for the issue queue stand-in.
// Pure declarations; no latency or backpressure of its own.
package issue_queue_model_pkg;

    localparam int ISSUE_QUEUE_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } issue_entry_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Issue queue storage: one write port, combinational read at the head.
// Write takes effect on the clock edge, read is zero-latency; no flow control here.
module sync_fifo_mem
    import issue_queue_model_pkg::*;
#(
    parameter int DEPTH  = ISSUE_QUEUE_DEPTH_DEFAULT,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              core_clk,
    input  logic              wr_vld,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    // Contents are never reset; occupancy tracking lives in the parent.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/issue_queue_model.sv
// Backend issue queue stand-in: FIFO drained at a programmable tick rate, 2-cycle min push-to-deq.
// Backpressure: ready drops while full, flushing or in reset; a same-cycle pop never bypasses full.
module issue_queue_model
    import issue_queue_model_pkg::*;
#(
    parameter int DEPTH        = ISSUE_QUEUE_DEPTH_DEFAULT,
    parameter int DATA_W       = 64,
    parameter int DRAIN_PERIOD = 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [DATA_W-1:0] issue_data_i,
    input  logic              drain_en_i,
    output logic              deq_valid_o,
    output logic [DATA_W-1:0] deq_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int DRAIN_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_PERIOD - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   head_ptr_q;
    logic [PTR_W-1:0]   tail_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic               deq_valid_q;
    logic [DATA_W-1:0]  deq_data_q;
    logic [DATA_W-1:0]  head_dat;

    logic full;
    logic empty;
    logic tick;
    logic push;
    logic pop;

    // Full/empty come from the count so pointer equality never has to be disambiguated.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign tick = drain_en_i && (drain_cnt_q == DRAIN_LAST);

    assign issue_ready_o = !full && !flush_i && !rst_i;
    assign push          = issue_valid_i && issue_ready_o;
    // Empty at the edge means no pop, even if a push lands the same cycle.
    assign pop           = tick && !empty;

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_mem (
        .core_clk (clk_i),
        .wr_vld   (push),
        .wr_addr  (tail_ptr_q),
        .wr_dat   (issue_data_i),
        .rd_addr  (head_ptr_q),
        .rd_dat   (head_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_ptr_q  <= '0;
            tail_ptr_q  <= '0;
            count_q     <= '0;
            drain_cnt_q <= '0;
            deq_valid_q <= 1'b0;
            deq_data_q  <= '0;
        end else if (flush_i) begin
            // deq_data_q keeps its last value; only the pulse is cleared.
            head_ptr_q  <= '0;
            tail_ptr_q  <= '0;
            count_q     <= '0;
            drain_cnt_q <= '0;
            deq_valid_q <= 1'b0;
        end else begin
            if (drain_en_i) begin
                drain_cnt_q <= tick ? '0 : drain_cnt_q + DRAIN_W'(1);
            end
            if (push) begin
                tail_ptr_q <= tail_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                head_ptr_q <= head_ptr_q + PTR_W'(1);
                deq_data_q <= head_dat;
            end
            deq_valid_q <= pop;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign deq_valid_o = deq_valid_q;
    assign deq_data_o  = deq_data_q;
    assign count_o     = count_q;

endmodule
